// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared encodings for the RV32I multicycle controller: opcode values, the
// FSM state enumeration, datapath mux selects, immediate formats and the two
// fixed ALU operations the controller issues on its own.
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, ILLEGAL
    } state_t;

    // Result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h8;

    // Immediate format implied by the opcode, used in DECODE so that ALUOut
    // holds OldPC + imm (the branch/jal target) by the next cycle.
    function automatic logic [2:0] imm_for_op(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OP_STORE:        sel = IMM_S;
            OP_BRANCH:       sel = IMM_B;
            OP_JAL:          sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:         sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
// Combinational branch resolution from the ALU flags of rs1 - rs2.
//   funct3 [2:0] in  : branch kind (IR[14:12])
//   flags  [3:0] in  : {N,Z,C,V}; C is the no-borrow carry (set when rs1 >= rs2 unsigned)
//   taken        out : branch condition holds
//   valid        out : funct3 names a defined branch (2 and 3 are reserved)
// ----------------------------------------------------------------------------
module branch_cond (
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       taken,
    output logic       valid
);

    logic n_s, z_s, c_s, v_s;

    assign n_s = flags[3];
    assign z_s = flags[2];
    assign c_s = flags[1];
    assign v_s = flags[0];

    // Condition select per branch kind
    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            3'd0:    taken = z_s;           // beq
            3'd1:    taken = ~z_s;          // bne
            3'd4:    taken = n_s ^ v_s;     // blt
            3'd5:    taken = ~(n_s ^ v_s);  // bge
            3'd6:    taken = ~c_s;          // bltu
            3'd7:    taken = c_s;           // bgeu
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// RV32I controller FSM for the shared-ALU / shared-memory multicycle core.
// Inputs : clk, rst_n (async, active low), op/funct3/funct7 from IR,
//          flags {N,Z,C,V} from the ALU, mem_ready from memory.
// Outputs: pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//          alu_src_a, alu_src_b, imm_src, alu_control, jalr_clr, retire,
//          illegal. All are decodes of the state register plus the inputs.
// ----------------------------------------------------------------------------
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT     = 1'b1,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       jalr_clr,
    output logic       retire,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic       mem_rdy_s, br_taken_s, br_valid_s;
    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s;
    logic       jalr_clr_s, retire_s, illegal_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s;
    logic [2:0] imm_src_s;
    logic [3:0] alu_ctrl_s;

    assign mem_rdy_s = MEM_WAIT ? mem_ready : 1'b1;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .flags  (flags),
        .taken  (br_taken_s),
        .valid  (br_valid_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        imm_src_s    = IMM_I;
        alu_ctrl_s   = ALU_ADD;
        jalr_clr_s   = 1'b0;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURES;
                if (mem_rdy_s) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = DECODE;
                end else begin
                    state_d    = FETCH;
                end
            end
            DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                imm_src_s   = imm_for_op(op);
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR1;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default: begin
                        if (TRAP_ILLEGAL) begin
                            state_d = ILLEGAL;
                        end else begin
                            // Unknown opcode retires as a NOP
                            retire_s = 1'b1;
                            state_d  = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                if (op == OP_LOAD) begin
                    imm_src_s = IMM_I;
                    state_d   = MEMREAD;
                end else begin
                    imm_src_s = IMM_S;
                    state_d   = MEMWRITE;
                end
            end
            MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_rdy_s) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                // Strobe stays high for the whole wait, memory samples it on ready
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_rdy_s) begin
                    retire_s = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d  = MEMWRITE;
                end
            end
            EXECR: begin
                alu_src_a_s = SRCA_RS1;
                alu_ctrl_s  = {funct7, funct3};
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                // IR[30] is an opcode modifier only for shifts; elsewhere it is immediate data
                if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
                    alu_ctrl_s = {funct7, funct3};
                end else begin
                    alu_ctrl_s = {1'b0, funct3};
                end
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_s = SRCA_RS1;
                alu_ctrl_s  = ALU_SUB;
                if (br_valid_s) begin
                    pc_write_s = br_taken_s;
                    retire_s   = 1'b1;
                    state_d    = FETCH;
                end else if (TRAP_ILLEGAL) begin
                    state_d    = ILLEGAL;
                end else begin
                    retire_s   = 1'b1;
                    state_d    = FETCH;
                end
            end
            JAL: begin
                // PC <= ALUOut (target from DECODE) while the ALU forms OldPC + 4 for rd
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_write_s  = 1'b1;
                state_d     = ALUWB;
            end
            JALR1: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                state_d     = JALR2;
            end
            JALR2: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                jalr_clr_s  = 1'b1;
                pc_write_s  = 1'b1;
                state_d     = ALUWB;
            end
            LUI: begin
                imm_src_s    = IMM_U;
                result_src_s = RES_IMM;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = FETCH;
            end
            AUIPC: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                imm_src_s   = IMM_U;
                state_d     = ALUWB;
            end
            ILLEGAL: begin
                illegal_s = 1'b1;
                state_d   = ILLEGAL;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // While reset is held the state already reads FETCH, which would otherwise
    // fetch on mem_ready; strobes are masked so nothing is written in reset.
    assign pc_write    = pc_write_s  & rst_n;
    assign mem_write   = mem_write_s & rst_n;
    assign ir_write    = ir_write_s  & rst_n;
    assign reg_write   = reg_write_s & rst_n;
    assign jalr_clr    = jalr_clr_s  & rst_n;
    assign retire      = retire_s    & rst_n;
    assign alu_control = rst_n ? alu_ctrl_s : 4'h0;
    assign adr_src     = adr_src_s;
    assign result_src  = result_src_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign imm_src     = imm_src_s;
    assign illegal     = illegal_s;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Randomized instruction stream against a per-instruction reference model.
// The driver pushes an expected summary of each instruction into a queue;
// a monitor tallies the DUT's strobes and pops/compares on every retire.
// Directed checks for reset, illegal trapping and reset during a store follow.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic [3:0] flags;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       jalr_clr, retire, illegal;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    typedef struct {
        int          kind;
        int          cycles;
        int          n_pc;
        int          n_ir;
        int          n_reg;
        int          n_mw;
        int          n_jc;
        logic [12:0] dec_sig;
        logic [12:0] ex_sig;
        logic [4:0]  ret_sig;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT(1'b1), .TRAP_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .flags(flags), .mem_ready(mem_ready), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .jalr_clr(jalr_clr), .retire(retire), .illegal(illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_LUI:   return 7'b0110111;
            default: return 7'b0010111;
        endcase
    endfunction

    // ALU flags {N,Z,C,V} of a - b, C meaning "no borrow"
    function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        return {d[31], (d == 32'd0), (a >= b), ((a[31] != b[31]) && (d[31] != a[31]))};
    endfunction

    // Expected observable summary of one instruction
    function automatic exp_t model(input int kind, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input int fw, input int mw);
        exp_t e;
        logic tk;
        logic [3:0] ic;
        int post;
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a < b);
            3'd7:    tk = (a >= b);
            default: tk = 1'b0;
        endcase
        ic = ((f3 == 3'd1) || (f3 == 3'd5)) ? {f7, f3} : {1'b0, f3};
        e.kind = kind; e.n_ir = 1; e.n_pc = 1; e.n_reg = 1; e.n_mw = 0; e.n_jc = 0;
        e.dec_sig = {2'b01, 2'b01, 3'b000, 4'h0, 2'b00};
        e.ret_sig = {2'b00, 1'b1, 1'b0, 1'b0};
        e.ex_sig  = 13'd0;
        post = 3;
        case (kind)
            K_R:   e.ex_sig = {2'b10, 2'b00, 3'b000, {f7, f3}, 2'b00};
            K_I:   e.ex_sig = {2'b10, 2'b01, 3'b000, ic, 2'b00};
            K_LD: begin
                post = 4 + mw;
                e.ex_sig  = {2'b10, 2'b01, 3'b000, 4'h0, 2'b00};
                e.ret_sig = {2'b01, 1'b1, 1'b0, 1'b0};
            end
            K_ST: begin
                post = 3 + mw;
                e.dec_sig = {2'b01, 2'b01, 3'b001, 4'h0, 2'b00};
                e.ex_sig  = {2'b10, 2'b01, 3'b001, 4'h0, 2'b00};
                e.ret_sig = {2'b00, 1'b0, 1'b0, 1'b1};
                e.n_reg = 0; e.n_mw = mw + 1;
            end
            K_BR: begin
                post = 2;
                e.dec_sig = {2'b01, 2'b01, 3'b010, 4'h0, 2'b00};
                e.ex_sig  = {2'b10, 2'b00, 3'b000, 4'h8, 2'b00};
                e.ret_sig = {2'b00, 1'b0, tk, 1'b0};
                e.n_reg = 0; e.n_pc = tk ? 2 : 1;
            end
            K_JAL: begin
                e.dec_sig = {2'b01, 2'b01, 3'b011, 4'h0, 2'b00};
                e.ex_sig  = {2'b01, 2'b10, 3'b000, 4'h0, 2'b00};
                e.n_pc = 2;
            end
            K_JALR: begin
                post = 4;
                e.ex_sig = {2'b10, 2'b01, 3'b000, 4'h0, 2'b00};
                e.n_pc = 2; e.n_jc = 1;
            end
            K_LUI: begin
                post = 2;
                e.dec_sig = {2'b01, 2'b01, 3'b100, 4'h0, 2'b00};
                e.ex_sig  = {2'b00, 2'b00, 3'b100, 4'h0, 2'b11};
                e.ret_sig = {2'b11, 1'b1, 1'b0, 1'b0};
            end
            default: begin
                e.dec_sig = {2'b01, 2'b01, 3'b100, 4'h0, 2'b00};
                e.ex_sig  = {2'b01, 2'b01, 3'b100, 4'h0, 2'b00};
            end
        endcase
        e.cycles = fw + 1 + post;
        return e;
    endfunction

    task automatic drive(input logic mr);
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction: fetch waits, then memory waits on the access phase
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b,
                             input int fw, input int mw);
        exp_t e;
        int post;
        bit is_mem;
        e = model(kind, f3, f7, a, b, fw, mw);
        exp_q.push_back(e);
        op = op_of(kind); funct3 = f3; funct7 = f7; flags = flags_of(a, b);
        is_mem = (kind == K_LD) || (kind == K_ST);
        repeat (fw) drive(1'b0);
        drive(1'b1);
        post = e.cycles - fw - 1;
        for (int j = 0; j < post; j++) begin
            if (is_mem && (j >= 2) && (j < 2 + mw)) drive(1'b0);
            else if (is_mem && (j == 2 + mw))       drive(1'b1);
            else                                    drive(1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: tally strobes per instruction, compare on retire
    initial begin
        int cnt, n_pc, n_ir, n_reg, n_mw, n_jc, ph;
        logic [12:0] dsig, xsig;
        exp_t e;
        cnt = 0; n_pc = 0; n_ir = 0; n_reg = 0; n_mw = 0; n_jc = 0; ph = 0;
        dsig = 13'd0; xsig = 13'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cnt++;
                n_pc += int'(pc_write); n_ir += int'(ir_write); n_reg += int'(reg_write);
                n_mw += int'(mem_write); n_jc += int'(jalr_clr);
                if (ph == 1) begin
                    dsig = {alu_src_a, alu_src_b, imm_src, alu_control, result_src};
                    ph = 2;
                end else if (ph == 2) begin
                    xsig = {alu_src_a, alu_src_b, imm_src, alu_control, result_src};
                    ph = 3;
                end
                if (ir_write && (ph == 0)) ph = 1;
                if (retire) begin
                    chk("retire_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("k%0d_cycles", e.kind), cnt, e.cycles);
                        chk($sformatf("k%0d_pc_write", e.kind), n_pc, e.n_pc);
                        chk($sformatf("k%0d_ir_write", e.kind), n_ir, e.n_ir);
                        chk($sformatf("k%0d_reg_write", e.kind), n_reg, e.n_reg);
                        chk($sformatf("k%0d_mem_write", e.kind), n_mw, e.n_mw);
                        chk($sformatf("k%0d_jalr_clr", e.kind), n_jc, e.n_jc);
                        chk($sformatf("k%0d_decode_sel", e.kind), dsig, e.dec_sig);
                        chk($sformatf("k%0d_exec_sel", e.kind), xsig, e.ex_sig);
                        chk($sformatf("k%0d_retire_sel", e.kind),
                            {result_src, reg_write, pc_write, adr_src}, e.ret_sig);
                    end
                    cnt = 0; n_pc = 0; n_ir = 0; n_reg = 0; n_mw = 0; n_jc = 0; ph = 0;
                end else if (cnt > 100) begin
                    chk("retire_budget", cnt, 100);
                    cnt = 0; ph = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int brf3 [6];
        int kind, fw, mw, guard;
        logic [2:0] f3;
        logic [31:0] a, b;
        brf3[0] = 0; brf3[1] = 1; brf3[2] = 4; brf3[3] = 5; brf3[4] = 6; brf3[5] = 7;

        rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'd0;
        funct7 = 1'b0; flags = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {pc_write, ir_write, mem_write, reg_write, retire, jalr_clr}, 6'b0);
        chk("reset_alu_control", alu_control, 4'h0);
        chk("reset_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed cases first
        run_instr(K_R,    3'd0, 1'b0, 32'd1, 32'd2, 0, 0);   // add
        run_instr(K_R,    3'd0, 1'b1, 32'd1, 32'd2, 0, 0);   // sub
        run_instr(K_I,    3'd5, 1'b1, 32'd1, 32'd2, 0, 0);   // srai
        run_instr(K_I,    3'd0, 1'b1, 32'd1, 32'd2, 0, 0);   // addi with IR[30] set
        run_instr(K_LD,   3'd2, 1'b0, 32'd0, 32'd0, 0, 3);   // lw, 3 waits
        run_instr(K_BR,   3'd0, 1'b0, 32'd5, 32'd5, 0, 0);   // beq taken
        run_instr(K_BR,   3'd0, 1'b0, 32'd5, 32'd6, 0, 0);   // beq not taken
        run_instr(K_BR,   3'd4, 1'b0, 32'hFFFF_FFF0, 32'd1, 0, 0); // blt taken
        run_instr(K_BR,   3'd7, 1'b0, 32'd1, 32'd2, 0, 0);   // bgeu not taken
        run_instr(K_JALR, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0);
        run_instr(K_ST,   3'd2, 1'b0, 32'd0, 32'd0, 1, 2);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 8);
            f3 = 3'($urandom_range(0, 7));
            if (kind == K_BR) f3 = 3'(brf3[$urandom_range(0, 5)]);
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = $urandom;
                default: b = {~a[31], a[30:0]};
            endcase
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            run_instr(kind, f3, 1'($urandom_range(0, 1)), a, b, fw, mw);
        end

        guard = 0;
        while ((exp_q.size() != 0) && (guard < 200)) begin
            drive(1'b0);
            guard++;
        end
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Undefined opcode traps and stays trapped
        op = 7'b1111111;
        drive(1'b1);
        drive(1'b0);
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("illegal_held", illegal, 1'b1);
            chk("illegal_no_strobes", {pc_write, ir_write, mem_write, reg_write, retire, jalr_clr}, 6'b0);
        end
        #2 rst_n = 1'b0;
        #1 chk("illegal_cleared_by_reset", illegal, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted while a store is waiting on memory
        op = 7'b0100011; funct3 = 3'd2;
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        @(negedge clk);
        chk("store_waiting_mem_write", mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("reset_drops_mem_write", mem_write, 1'b0);
        chk("reset_adr_src", adr_src, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("restart_fetch_strobes", {ir_write, pc_write, mem_write}, 3'b110);
        chk("restart_illegal", illegal, 1'b0);

        // Reserved branch funct3 traps without writing or retiring
        @(posedge clk);
        #1 op = 7'b1100011; funct3 = 3'd2; flags = 4'b0100;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bad_branch_no_retire", {pc_write, retire}, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bad_branch_traps", illegal, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
